// File: rtl/rf_write_scheduler_if.sv
// Write-back request / register-file write-port bundle for rf_write_scheduler.
// master = write-back sources side, slave = scheduler side.
interface rf_write_scheduler_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic [ADDR_W-1:0] rf_a3;
  logic [DATA_W-1:0] rf_wd3;
  logic              rf_we3;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  rf_a3, rf_wd3, rf_we3
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output rf_a3, rf_wd3, rf_we3
  );
endinterface

// File: rtl/rf_write_scheduler.sv
// Register-file write-port sequencer: clears x1..x(2**ADDR_W-1) after reset, then
// round-robin arbitrates two write-back requesters. Optional read forwarding: RF_BYPASS_EN.
module rf_write_scheduler #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              areset_i,
  rf_write_scheduler_if.slave wb_if,
  output logic              init_done_o
`ifdef RF_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] rd_a1_i,
  input  logic [ADDR_W-1:0] rd_a2_i,
  input  logic [DATA_W-1:0] rf_rd1_i,
  input  logic [DATA_W-1:0] rf_rd2_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o
`endif
);

  localparam logic StInit = 1'b0;
  localparam logic StRun  = 1'b1;
  localparam logic [ADDR_W-1:0] LastAddr = '1;

  logic              state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rr_q, rr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] a3_q, a3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;
  logic              init_done_q, init_done_d;

  logic run, grant0, grant1;

  // rr_q selects the requester that wins a tie.
  always_comb begin
    run    = (state_q == StRun);
    grant0 = run & wb_if.req0_valid & (~wb_if.req1_valid | ~rr_q);
    grant1 = run & wb_if.req1_valid & (~wb_if.req0_valid | rr_q);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    we_d        = 1'b0;
    a3_d        = a3_q;
    wd3_d       = wd3_q;
    init_done_d = init_done_q;
    if (state_q == StInit) begin
      we_d  = 1'b1;
      a3_d  = cnt_q;
      wd3_d = '0;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LastAddr) begin
        state_d     = StRun;
        init_done_d = 1'b1;
      end
    end else if (grant0) begin
      a3_d  = wb_if.req0_addr;
      wd3_d = wb_if.req0_data;
      we_d  = (wb_if.req0_addr != '0);
      rr_d  = 1'b1;
    end else if (grant1) begin
      a3_d  = wb_if.req1_addr;
      wd3_d = wb_if.req1_data;
      we_d  = (wb_if.req1_addr != '0);
      rr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (areset_i) begin
      state_q     <= StInit;
      cnt_q       <= {{(ADDR_W-1){1'b0}}, 1'b1};
      rr_q        <= 1'b0;
      we_q        <= 1'b0;
      a3_q        <= '0;
      wd3_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      we_q        <= we_d;
      a3_q        <= a3_d;
      wd3_q       <= wd3_d;
      init_done_q <= init_done_d;
    end
  end

  assign wb_if.req0_ready = grant0;
  assign wb_if.req1_ready = grant1;
  assign wb_if.rf_we3     = we_q;
  assign wb_if.rf_a3      = a3_q;
  assign wb_if.rf_wd3     = wd3_q;
  assign init_done_o      = init_done_q;

`ifdef RF_BYPASS_EN
  // Forward the in-flight write so readers see it before the register file commits.
  assign rd1_o = (we_q && (a3_q == rd_a1_i) && (rd_a1_i != '0)) ? wd3_q : rf_rd1_i;
  assign rd2_o = (we_q && (a3_q == rd_a2_i) && (rd_a2_i != '0)) ? wd3_q : rf_rd2_i;
`endif

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Scoreboard bench for rf_write_scheduler: a reference model predicts grants and
// register-file writes; a negedge monitor pops and compares every presented write.
module tb_rf_write_scheduler;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic areset;
  logic init_done;
  always #5 clk = ~clk;

  rf_write_scheduler_if #(.DATA_W(DW), .ADDR_W(AW)) ifc ();

`ifdef RF_BYPASS_EN
  logic [AW-1:0] rd_a1, rd_a2;
  logic [DW-1:0] rf_rd1, rf_rd2, rd1, rd2;
`endif

  rf_write_scheduler #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i       (clk),
    .areset_i    (areset),
    .wb_if       (ifc),
    .init_done_o (init_done)
`ifdef RF_BYPASS_EN
    ,
    .rd_a1_i     (rd_a1),
    .rd_a2_i     (rd_a2),
    .rf_rd1_i    (rf_rd1),
    .rf_rd2_i    (rf_rd2),
    .rd1_o       (rd1),
    .rd2_o       (rd2)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] exp_w;
  logic [DW-1:0]    model_regs [32];
  int               model_edges;
  int               model_rr;

  // Register file fed by the DUT's write port
  logic [DW-1:0] mem [32] = '{default: '0};
  always @(posedge clk) if (ifc.rf_we3) mem[ifc.rf_a3] <= ifc.rf_wd3;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!areset && ifc.rf_we3) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got a3=%0d wd3=%h, required no write at %0t",
                 ifc.rf_a3, ifc.rf_wd3, $time);
      end else begin
        exp_w = exp_q.pop_front();
        check("rf_write", {27'd0, ifc.rf_a3, ifc.rf_wd3}, {27'd0, exp_w});
      end
    end
  end

  // Entered and left at posedge+1; reset is applied for n edges.
  task automatic reset_dut(input int n);
    areset = 1'b1;
    exp_q.delete();
    repeat (n) @(posedge clk);
    #1;
    areset = 1'b0;
    model_edges = 0;
    model_rr = 0;
    model_regs[0] = '0;
    for (int i = 1; i < 32; i++) begin
      logic [AW-1:0] a;
      a = AW'(i);
      exp_q.push_back({a, 32'h0});
      model_regs[i] = '0;
    end
  endtask

  // One cycle: predict grant from the currently driven requests, check, advance.
  task automatic step(output int g);
    int  eg;
    logic run;
    #1;
    run = (model_edges >= 31);
    check("init_done", {63'd0, init_done}, {63'd0, run});
    eg = -1;
    if (run) begin
      if (ifc.req0_valid && ifc.req1_valid) eg = model_rr;
      else if (ifc.req0_valid) eg = 0;
      else if (ifc.req1_valid) eg = 1;
    end
    check("req0_ready", {63'd0, ifc.req0_ready}, {63'd0, (eg == 0)});
    check("req1_ready", {63'd0, ifc.req1_ready}, {63'd0, (eg == 1)});
    if (eg == 0) begin
      model_rr = 1;
      if (ifc.req0_addr != '0) begin
        exp_q.push_back({ifc.req0_addr, ifc.req0_data});
        model_regs[ifc.req0_addr] = ifc.req0_data;
      end
    end else if (eg == 1) begin
      model_rr = 0;
      if (ifc.req1_addr != '0) begin
        exp_q.push_back({ifc.req1_addr, ifc.req1_data});
        model_regs[ifc.req1_addr] = ifc.req1_data;
      end
    end
    @(posedge clk);
    #1;
    model_edges++;
    g = eg;
  endtask

  initial begin
    int g;
    areset = 1'b1;
    ifc.req0_valid = 1'b0; ifc.req0_addr = '0; ifc.req0_data = '0;
    ifc.req1_valid = 1'b0; ifc.req1_addr = '0; ifc.req1_data = '0;
`ifdef RF_BYPASS_EN
    rd_a1 = '0; rd_a2 = '0; rf_rd1 = '0; rf_rd2 = '0;
`endif
    @(posedge clk);
    #1;
    check("reset_we3", {63'd0, ifc.rf_we3}, 64'd0);
    check("reset_a3", {59'd0, ifc.rf_a3}, 64'd0);
    check("reset_wd3", {32'd0, ifc.rf_wd3}, 64'd0);
    reset_dut(2);

    // Sweep with no requests, then one idle RUN cycle
    repeat (32) step(g);

    // Contention: both valid for 4 cycles
    ifc.req0_valid = 1'b1; ifc.req0_addr = 5'd3; ifc.req0_data = 32'h11;
    ifc.req1_valid = 1'b1; ifc.req1_addr = 5'd4; ifc.req1_data = 32'h22;
    repeat (4) step(g);
    ifc.req0_valid = 1'b0; ifc.req1_valid = 1'b0;

    // Single requester
    ifc.req0_valid = 1'b1; ifc.req0_addr = 5'd5; ifc.req0_data = 32'hDEADBEEF;
    step(g);
    ifc.req0_valid = 1'b0;
    repeat (2) step(g);

    // x0 write is acknowledged but suppressed
    ifc.req1_valid = 1'b1; ifc.req1_addr = 5'd0; ifc.req1_data = 32'hFFFFFFFF;
    step(g);
    ifc.req1_valid = 1'b0;
    step(g);

    // Reset lands on a handshake cycle: that write must never appear
    ifc.req0_valid = 1'b1; ifc.req0_addr = 5'd12; ifc.req0_data = 32'hA5A5_0012;
    reset_dut(1);

    // Reset mid-sweep at counter 10 with both requesters held
    ifc.req1_valid = 1'b1; ifc.req1_addr = 5'd6; ifc.req1_data = 32'h66;
    repeat (9) step(g);
    reset_dut(2);
    repeat (31) step(g);

    // Randomised traffic; requesters hold until accepted
    repeat (400) begin
      if (!ifc.req0_valid && ($urandom_range(0, 2) != 0)) begin
        ifc.req0_valid = 1'b1;
        ifc.req0_addr  = AW'($urandom_range(0, 31));
        ifc.req0_data  = $urandom;
      end
      if (!ifc.req1_valid && ($urandom_range(0, 2) != 0)) begin
        ifc.req1_valid = 1'b1;
        ifc.req1_addr  = AW'($urandom_range(0, 31));
        ifc.req1_data  = $urandom;
      end
      step(g);
      if (g == 0) ifc.req0_valid = 1'b0;
      if (g == 1) ifc.req1_valid = 1'b0;
    end
    ifc.req0_valid = 1'b0; ifc.req1_valid = 1'b0;
    step(g);

`ifdef RF_BYPASS_EN
    rd_a1 = 5'd7; rf_rd1 = '0; rd_a2 = 5'd0; rf_rd2 = 32'hCAFE;
    ifc.req0_valid = 1'b1; ifc.req0_addr = 5'd7; ifc.req0_data = 32'h1234;
    step(g);
    ifc.req0_valid = 1'b0;
    check("bypass_rd1", {32'd0, rd1}, 64'h1234);
    check("bypass_rd2", {32'd0, rd2}, 64'hCAFE);
    ifc.req1_valid = 1'b1; ifc.req1_addr = 5'd0; ifc.req1_data = 32'h5555;
    step(g);
    ifc.req1_valid = 1'b0;
    check("bypass_rd1_idle", {32'd0, rd1}, 64'h0);
    check("bypass_rd2_x0", {32'd0, rd2}, 64'hCAFE);
`endif

    repeat (3) step(g);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("regfile_x%0d", i), {32'd0, mem[i]}, {32'd0, model_regs[i]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_write_scheduler.md
# rf_write_scheduler

Sequencer and arbiter for the register file write port (A3/WD3/WE3). After reset it clears x1..x31 with a hardware sweep, then arbitrates between two write-back requesters (e.g. ALU and load/CSR unit) with valid/ready handshakes. Grants alternate round-robin, and the selected write is driven as registered outputs to the register file. It sits between the write-back sources and the register file; every write-port access passes through it.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (2**ADDR_W registers)
- clk  in  1  clock, all state on rising edge
- areset  in  1  synchronous reset, active-high
- req0_valid  in  1  requester 0 has a write pending
- req0_addr  in  ADDR_W  requester 0 destination register
- req0_data  in  DATA_W  requester 0 write data
- req0_ready  out  1  requester 0 write accepted this cycle
- req1_valid / req1_addr / req1_data / req1_ready: same as requester 0, for requester 1
- rf_a3  out  ADDR_W  register file write address (registered)
- rf_wd3  out  DATA_W  register file write data (registered)
- rf_we3  out  1  register file write enable (registered)
- init_done  out  1  high once the clear sweep has issued its last write
- rd_a1, rd_a2  in  ADDR_W  read addresses (RF_BYPASS_EN only)
- rf_rd1, rf_rd2  in  DATA_W  raw register file read data (RF_BYPASS_EN only)
- rd1, rd2  out  DATA_W  forwarded read data (RF_BYPASS_EN only)

## Operation
- Clock and reset: one clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - state=INIT, sweep counter=1, rr pointer=0 (requester 0 preferred).
  - rf_we3=0, rf_a3=0, rf_wd3=0, init_done=0.
- States:
  - INIT: each edge loads rf_we3=1, rf_a3=counter, rf_wd3=0, then increments counter.
  - INIT → RUN: on the edge that loads rf_a3=2**ADDR_W-1; the same edge sets init_done=1.
  - x0 is never written by the sweep.
- In INIT: req0_ready=req1_ready=0; requests are held off, not dropped.
- RUN arbitration (combinational, per cycle):
  - Only one valid: that requester is granted.
  - Both valid: the requester indicated by the rr pointer is granted.
  - reqN_ready = RUN & grantN. At most one ready per cycle.
  - Ready depends on valid; requesters must not make valid depend on ready.
- On a grant, the edge loads rf_a3/rf_wd3 from the granted requester and sets rf_we3=1.
  - Exception: if the granted addr==0, rf_we3=0. The request is still acknowledged (consumed), but x0 is not written.
- rr pointer: after any grant it points to the other requester; with no grant it is unchanged.
- No grant in a cycle: the edge loads rf_we3=0. rf_a3/rf_wd3 hold their previous values.
- Requester contract: valid, addr and data stay stable until ready is seen.

## Timing
- Reset release:
  - Edges 1..31 after the last reset cycle present writes to x1..x31.
  - init_done rises on edge 31.
  - First grant is possible in the cycle after edge 31; it appears on rf_* at edge 32.
- Accept-to-write latency: handshake in cycle N, rf_we3 high during cycle N+1, and the register file commits at the end of cycle N+1.
- Throughput: one write per cycle sustained.
- Both requesters continuously valid: grants alternate 0,1,0,1… (after reset, starting with 0).
- Reset mid-sweep or mid-RUN (synchronous):
  - All state returns to reset values and the sweep restarts from x1.
  - Any accepted-but-not-yet-presented write is discarded.
- rf_* outputs never change except on clk edges.

## Configuration
- RF_BYPASS_EN defined:
  - Ports rd_a1/rd_a2/rf_rd1/rf_rd2/rd1/rd2 exist.
  - rdK = (rf_we3 && rf_a3==rd_aK && rd_aK!=0) ? rf_wd3 : rf_rdK, purely combinational.
  - This returns the value being written this cycle before the register file commits it.
- RF_BYPASS_EN undefined: these ports and the forwarding logic are absent. Consumers read the register file directly and see a written value only from the cycle after rf_we3.

## Test plan
- Reset sweep: hold areset 2 cycles, release → rf_we3=1 with rf_a3=1..31 and rf_wd3=0 on edges 1..31; init_done=1 from edge 31; ready stays 0 throughout; afterwards, x1..x31 read as 0.
- Single requester: req0 valid, addr=5, data=0xDEADBEEF in RUN → req0_ready=1 same cycle; next cycle rf_we3=1, rf_a3=5, rf_wd3=0xDEADBEEF; following cycle rf_we3=0.
- Contention: both valid continuously, req0 addr=3/data=0x11, req1 addr=4/data=0x22, 4 cycles → grants 0,1,0,1; rf_a3 sequence 3,4,3,4; readies never both high.
- x0 write: req1 valid, addr=0, data=0xFFFFFFFF → req1_ready=1; next cycle rf_we3=0; x0 still reads 0.
- Reset mid-operation: assert areset at sweep counter=10, release → sweep restarts at rf_a3=1; rr pointer=0; a held req1 is not granted until after init_done.
- Bypass (RF_BYPASS_EN): write x7=0x1234 while rd_a1=7 and rf_rd1=0 → rd1=0x1234 during the rf_we3 cycle; rd_a2=0 with rf_a3=0 → rd2=rf_rd2.
